image_stream_reader: RTL

- Read-side master for the single-port image RAM (1-cycle registered-address read, q valid the cycle after the address is presented).
- On a start pulse, it walks the image in raster order from BASE_ADDR and emits one pixel per beat on a valid/ready stream with frame and line markers.
- It feeds the display/processing pipeline that consumes the preloaded or written image.

---
 rtl/image_stream_pkg.sv | 23 ++
 rtl/stream_skid_fifo.sv | 52 +++++
 rtl/image_stream_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/image_stream_pkg.sv
// Shared types for the image stream reader: FSM state, tagged pixel beat and frame-size helper.
package image_stream_pkg;

    localparam int PIX_D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fsm_t;

    typedef struct packed {
        logic [PIX_D_WIDTH-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } pix_beat_t;

    function automatic int frame_pixels(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry valid/ready FIFO for stream beats; exposes occupancy so an upstream
// issuer with read latency can do its own credit check.
module stream_skid_fifo
    import image_stream_pkg::*;
#(
    parameter type T = pix_beat_t
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_push,
    input  T           i_data,
    output logic       o_valid,
    output T           o_data,
    input  logic       i_ready,
    output logic [1:0] o_count
);

    T           r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the two storage slots are reset too, so the head beat (and the
            // pixel data it drives) reads as zero straight out of reset.
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/image_stream_reader.sv
// Raster-order reader of the image RAM onto a valid/ready pixel stream with sof/eol/eof tags.
// Optional continuous-frame mode is enabled by defining IMAGE_STREAM_READER_LOOP_EN.
module image_stream_reader
    import image_stream_pkg::*;
#(
    parameter int D_WIDTH   = PIX_D_WIDTH,
    parameter int A_WIDTH   = 16,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int BASE_ADDR = 0
) (
`ifdef IMAGE_STREAM_READER_LOOP_EN
    input  logic               loop,
`endif
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] ram_address,
    input  logic [D_WIDTH-1:0] ram_q,
    output logic [D_WIDTH-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof
);

    localparam int FRAME_PIX = frame_pixels(IMG_W, IMG_H);
    localparam int X_BITS    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_BITS    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (D_WIDTH != PIX_D_WIDTH) begin : g_width_check
        $error("image_stream_reader: D_WIDTH must equal PIX_D_WIDTH");
    end
    if (FRAME_PIX < 2) begin : g_size_check
        $error("image_stream_reader: frame must hold at least two pixels");
    end

    fsm_t               r_state;
    fsm_t               w_next_state;
    logic [X_BITS-1:0]  r_x;
    logic [Y_BITS-1:0]  r_y;
    logic               r_issue_d;
    logic               r_sof_d;
    logic               r_eol_d;
    logic               r_eof_d;
    logic [A_WIDTH-1:0] r_ram_address;
    logic               r_done;

    logic               w_issue;
    logic               w_loop;
    logic               w_x_last;
    logic               w_y_last;
    logic               w_last_issue;
    logic [A_WIDTH-1:0] w_addr;
    logic [2:0]         w_credit;
    logic               w_credit_ok;
    logic [1:0]         w_fifo_count;
    logic               w_fifo_valid;
    logic               w_pop;
    pix_beat_t          w_head;
    pix_beat_t          w_push_beat;

`ifdef IMAGE_STREAM_READER_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_x_last     = (r_x == X_BITS'(IMG_W - 1));
    assign w_y_last     = (r_y == Y_BITS'(IMG_H - 1));
    assign w_last_issue = w_x_last && w_y_last;
    assign w_addr       = A_WIDTH'(BASE_ADDR) + A_WIDTH'(r_y) * A_WIDTH'(IMG_W) + A_WIDTH'(r_x);

    // Buffered beats plus the read still in the RAM pipe must leave room for one more.
    assign w_pop       = w_fifo_valid && pix_ready;
    assign w_credit    = 3'(w_fifo_count) + 3'(r_issue_d) - 3'(w_pop);
    assign w_credit_ok = (w_credit < 3'd2);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_issue      = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_last_issue && !w_loop) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop && w_head.eof) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_issue_d     <= 1'b0;
            r_sof_d       <= 1'b0;
            r_eol_d       <= 1'b0;
            r_eof_d       <= 1'b0;
            r_ram_address <= A_WIDTH'(BASE_ADDR);
            r_done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // values from before this edge, independent of statement order.
            r_state   <= w_next_state;
            r_issue_d <= w_issue;
            r_done    <= w_pop && w_head.eof;
            if (w_issue) begin
                r_sof_d       <= (r_x == '0) && (r_y == '0);
                r_eol_d       <= w_x_last;
                r_eof_d       <= w_last_issue;
                r_ram_address <= w_addr;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // RAM data arrives one cycle after issue and is tagged with the delayed flags.
    assign w_push_beat = '{data: ram_q, sof: r_sof_d, eol: r_eol_d, eof: r_eof_d};

    stream_skid_fifo #(
        .T(pix_beat_t)
    ) u_out_fifo (
        .clock  (clock),
        .reset  (reset),
        .i_push (r_issue_d),
        .i_data (w_push_beat),
        .o_valid(w_fifo_valid),
        .o_data (w_head),
        .i_ready(pix_ready),
        .o_count(w_fifo_count)
    );

    assign ram_address = w_issue ? w_addr : r_ram_address;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign pix_valid   = w_fifo_valid;
    assign pix_data    = w_head.data;
    assign pix_sof     = w_fifo_valid && w_head.sof;
    assign pix_eol     = w_fifo_valid && w_head.eol;
    assign pix_eof     = w_fifo_valid && w_head.eof;

endmodule
